ram_port_arbiter: RTL and testbench

Two-client arbiter in front of the synchronous dual-port RAM (`ram`), sharing its single write port and single read port between client 0 and client 1. Write and read ports are arbitrated independently, each round-robin, so one client's read and the other's write proceed in the same cycle. Read data is returned to the owning client with a valid strobe. It sits between the memory subsystem's requesters and the `ram` instance.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/ram_port_arbiter_rr_arb2.sv | 34 +++
 rtl/ram_port_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the two-client RAM port arbiter.
package ram_arb_pkg;

   localparam int NUM_CLIENTS = 2;

   // Client identifier: 0 or 1.
   typedef logic client_id_t;

   // One stage of the read-return pipeline: is a read in flight, and whose is it.
   typedef struct packed {
      logic       valid;
      client_id_t owner;
   } rd_pipe_t;

   // Convert a one-hot 2-way grant into the winning client ID.
   function automatic client_id_t onehot2_to_id(input logic [1:0] oh);
      return oh[1];
   endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a combinational one-hot grant.
// The registered pointer remembers the last winner so a tie goes to the other client.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic r_last;

   // Grant decision: single requester wins outright, a tie goes to the client not granted last.
   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Pointer update: remember the winner of every grant; reset favours client 0 on the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= 1'b1;
      end else if (|gnt) begin
         r_last <= gnt[1];
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM write port and one RAM read port between two clients.
// Each port has its own round-robin arbiter, so a read and a write proceed together.
// Read data comes back two cycles after grant, steered by an owner pipeline.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  c0_req,
   input  logic                  c0_we,
   input  logic [ADDR_WIDTH-1:0] c0_addr,
   input  logic [DATA_WIDTH-1:0] c0_wdata,
   input  logic                  c1_req,
   input  logic                  c1_we,
   input  logic [ADDR_WIDTH-1:0] c1_addr,
   input  logic [DATA_WIDTH-1:0] c1_wdata,
   output logic                  c0_gnt,
   output logic                  c1_gnt,
   output logic                  c0_rvalid,
   output logic                  c1_rvalid,
   output logic [DATA_WIDTH-1:0] c0_rdata,
   output logic [DATA_WIDTH-1:0] c1_rdata,
   output logic                  ram_we,
   output logic                  ram_re,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out
);

   logic [1:0]            w_wr_req;
   logic [1:0]            w_rd_req;
   logic [1:0]            w_wr_gnt;
   logic [1:0]            w_rd_gnt;
   client_id_t            w_wr_sel;
   client_id_t            w_rd_sel;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [DATA_WIDTH-1:0] w_wr_data;
   logic [ADDR_WIDTH-1:0] w_rd_addr;

   logic                  r_ram_we;
   logic                  r_ram_re;
   logic [ADDR_WIDTH-1:0] r_ram_wr_addr;
   logic [ADDR_WIDTH-1:0] r_ram_rd_addr;
   logic [DATA_WIDTH-1:0] r_ram_data_in;
   rd_pipe_t              r_pipe_s0;
   rd_pipe_t              r_pipe_s1;

   logic [NUM_CLIENTS-1:0] w_rvalid;
   logic [DATA_WIDTH-1:0]  w_rdata [NUM_CLIENTS];

   // Each port only sees the requests of its own command type.
   assign w_wr_req = {c1_req &  c1_we, c0_req &  c0_we};
   assign w_rd_req = {c1_req & ~c1_we, c0_req & ~c0_we};

   rr_arb2 u_wr_arb (
      .clk (clk),
      .rst (rst),
      .req (w_wr_req),
      .gnt (w_wr_gnt)
   );

   rr_arb2 u_rd_arb (
      .clk (clk),
      .rst (rst),
      .req (w_rd_req),
      .gnt (w_rd_gnt)
   );

   // A client issues one command at a time, so at most one port grants it.
   assign c0_gnt = w_wr_gnt[0] | w_rd_gnt[0];
   assign c1_gnt = w_wr_gnt[1] | w_rd_gnt[1];

   // Command muxes driven by the per-port winner.
   assign w_wr_sel  = onehot2_to_id(w_wr_gnt);
   assign w_rd_sel  = onehot2_to_id(w_rd_gnt);
   assign w_wr_addr = w_wr_sel ? c1_addr  : c0_addr;
   assign w_wr_data = w_wr_sel ? c1_wdata : c0_wdata;
   assign w_rd_addr = w_rd_sel ? c1_addr  : c0_addr;

   // RAM command registers: enables pulse for one cycle per grant, address/data hold when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ram_we      <= 1'b0;
         r_ram_re      <= 1'b0;
         r_ram_wr_addr <= '0;
         r_ram_rd_addr <= '0;
         r_ram_data_in <= '0;
      end else begin
         r_ram_we <= |w_wr_gnt;
         r_ram_re <= |w_rd_gnt;
         if (|w_wr_gnt) begin
            r_ram_wr_addr <= w_wr_addr;
            r_ram_data_in <= w_wr_data;
         end
         if (|w_rd_gnt) begin
            r_ram_rd_addr <= w_rd_addr;
         end
      end
   end

   // Read-owner pipeline: stage 0 lines up with ram_re, stage 1 with ram_data_out; reset flushes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pipe_s0 <= '0;
         r_pipe_s1 <= '0;
      end else begin
         r_pipe_s0.valid <= |w_rd_gnt;
         r_pipe_s0.owner <= w_rd_sel;
         r_pipe_s1       <= r_pipe_s0;
      end
   end

   // Steer returning read data to its owner; non-owners see zero.
   generate
      for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_return
         assign w_rvalid[gi] = r_pipe_s1.valid && (r_pipe_s1.owner == client_id_t'(gi));
         assign w_rdata[gi]  = w_rvalid[gi] ? ram_data_out : '0;
      end
   endgenerate

   assign c0_rvalid   = w_rvalid[0];
   assign c1_rvalid   = w_rvalid[1];
   assign c0_rdata    = w_rdata[0];
   assign c1_rdata    = w_rdata[1];
   assign ram_we      = r_ram_we;
   assign ram_re      = r_ram_re;
   assign ram_wr_addr = r_ram_wr_addr;
   assign ram_rd_addr = r_ram_rd_addr;
   assign ram_data_in = r_ram_data_in;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM and a read-data scoreboard.
module tb_ram_port_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       c0_req, c0_we, c1_req, c1_we;
   logic [7:0] c0_addr, c0_wdata, c1_addr, c1_wdata;
   logic       c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
   logic [7:0] c0_rdata, c1_rdata;
   logic       ram_we, ram_re;
   logic [7:0] ram_wr_addr, ram_rd_addr, ram_data_in, ram_data_out;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      int         owner;
      logic [7:0] data;
      int         due;
   } exp_t;

   exp_t       q[$];
   logic [7:0] shadow [256];
   logic [7:0] mem [256];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
      .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
      .c0_gnt(c0_gnt), .c1_gnt(c1_gnt),
      .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
      .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
      .ram_we(ram_we), .ram_re(ram_re),
      .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
      .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
   );

   // Behavioural synchronous dual-port RAM: read returns old data on a same-address collision.
   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]    = 8'h00;
         shadow[i] = 8'h00;
      end
   end
   always @(posedge clk) begin
      if (ram_we) mem[ram_wr_addr] <= ram_data_in;
      if (ram_re) ram_data_out <= mem[ram_rd_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: check returning reads, then log this cycle's read grants and writes.
   always @(negedge clk) begin
      exp_t e;
      bit   due;
      if (rst) begin
         q.delete();
      end else begin
         due = (q.size() > 0) && (q[0].due == cyc);
         if (due) e = q.pop_front();
         chk("sb_rvalid", {30'd0, c1_rvalid, c0_rvalid}, due ? (32'd1 << e.owner) : 32'd0);
         if (due) chk("sb_rdata", {24'd0, (e.owner == 0) ? c0_rdata : c1_rdata}, {24'd0, e.data});
         if (c0_gnt && !c0_we) q.push_back('{0, shadow[c0_addr], cyc + 2});
         if (c1_gnt && !c1_we) q.push_back('{1, shadow[c1_addr], cyc + 2});
         if (c0_gnt && c0_we) shadow[c0_addr] = c0_wdata;
         if (c1_gnt && c1_we) shadow[c1_addr] = c1_wdata;
      end
   end

   task automatic drive(input int c, input logic req, input logic we,
                        input logic [7:0] addr, input logic [7:0] wd);
      if (c == 0) begin
         c0_req = req; c0_we = we; c0_addr = addr; c0_wdata = wd;
      end else begin
         c1_req = req; c1_we = we; c1_addr = addr; c1_wdata = wd;
      end
   endtask

   task automatic idle();
      c0_req = 1'b0;
      c1_req = 1'b0;
   endtask

   task automatic cyc_start();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 1'b1, 1'b1, 8'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat (3) @(posedge clk);
      mid();
      chk("reset_gnt", {30'd0, c1_gnt, c0_gnt}, 32'd0);
      chk("reset_ram", {6'd0, ram_we, ram_re, ram_wr_addr, ram_rd_addr, ram_data_in}, 32'd0);
      chk("reset_rd", {14'd0, c1_rvalid, c0_rvalid, c1_rdata, c0_rdata}, 32'd0);

      // Single write from client 0.
      cyc_start(); rst = 1'b0;
      drive(0, 1'b1, 1'b1, 8'h10, 8'hA5);
      mid();
      chk("wr_gnt", {30'd0, c1_gnt, c0_gnt}, 32'd1);
      cyc_start(); idle();
      mid();
      chk("wr_ram", {ram_we, ram_wr_addr, ram_data_in}, {1'b1, 8'h10, 8'hA5});
      cyc_start();
      mid();
      chk("wr_idle", {ram_we, ram_re, ram_wr_addr, ram_data_in}, {1'b0, 1'b0, 8'h10, 8'hA5});

      // Read it back from client 0.
      cyc_start(); drive(0, 1'b1, 1'b0, 8'h10, 8'h00);
      mid();
      chk("rd_gnt", {30'd0, c1_gnt, c0_gnt}, 32'd1);
      cyc_start(); idle();
      mid();
      chk("rd_ram", {ram_re, ram_rd_addr}, {1'b1, 8'h10});
      cyc_start();
      mid();
      chk("rd_ret", {c1_rvalid, c0_rvalid, c0_rdata}, {1'b0, 1'b1, 8'hA5});

      // Prime write pointer with a client-1 grant, then a sustained tie alternates from client 0.
      cyc_start(); drive(1, 1'b1, 1'b1, 8'h03, 8'h77);
      mid();
      chk("c1_wr_gnt", {30'd0, c1_gnt, c0_gnt}, 32'd2);
      cyc_start();
      drive(0, 1'b1, 1'b1, 8'h01, 8'h11);
      drive(1, 1'b1, 1'b1, 8'h02, 8'h22);
      for (int i = 0; i < 4; i++) begin
         mid();
         chk("tie_alt", {30'd0, c1_gnt, c0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
         if (i > 0) chk("tie_addr", {24'd0, ram_wr_addr}, (i % 2 == 1) ? 32'h01 : 32'h02);
         cyc_start();
      end
      idle();

      // Write and read of the same address in the same cycle: the read sees old data.
      drive(0, 1'b1, 1'b1, 8'h20, 8'h3C);
      drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
      mid();
      chk("rw_gnt", {30'd0, c1_gnt, c0_gnt}, 32'd3);
      cyc_start(); idle();
      mid();
      chk("rw_ram", {30'd0, ram_we, ram_re}, 32'd3);
      cyc_start();
      mid();
      chk("rw_old", {c1_rvalid, c1_rdata}, {1'b1, 8'h00});
      cyc_start(); drive(1, 1'b1, 1'b0, 8'h20, 8'h00);
      mid();
      chk("rw_gnt2", {30'd0, c1_gnt, c0_gnt}, 32'd2);
      cyc_start(); idle();
      cyc_start();
      mid();
      chk("rw_new", {c1_rvalid, c1_rdata}, {1'b1, 8'h3C});

      // Fill all locations with data = addr from alternating clients, then read back.
      for (int a = 0; a < 256; a++) begin
         cyc_start(); idle();
         drive(a % 2, 1'b1, 1'b1, 8'(a), 8'(a));
         mid();
         chk("fill_gnt", {30'd0, c1_gnt, c0_gnt}, (a % 2 == 0) ? 32'd1 : 32'd2);
      end
      for (int a = 0; a < 256; a++) begin
         cyc_start(); idle();
         drive((a + 1) % 2, 1'b1, 1'b0, 8'(a), 8'h00);
         mid();
         chk("read_gnt", {30'd0, c1_gnt, c0_gnt}, (a % 2 == 0) ? 32'd2 : 32'd1);
      end
      cyc_start(); idle();
      repeat (3) cyc_start();

      // Reset right after a read grant flushes the return.
      drive(0, 1'b1, 1'b0, 8'h05, 8'h00);
      mid();
      chk("flush_gnt", {30'd0, c1_gnt, c0_gnt}, 32'd1);
      cyc_start(); rst = 1'b1;
      idle();
      drive(1, 1'b1, 1'b0, 8'h06, 8'h00);
      mid();
      chk("rst_no_gnt", {30'd0, c1_gnt, c0_gnt}, 32'd0);
      cyc_start();
      mid();
      chk("flush_out", {28'd0, c1_rvalid, c0_rvalid, ram_we, ram_re}, 32'd0);
      cyc_start(); rst = 1'b0;
      drive(0, 1'b1, 1'b1, 8'h40, 8'h44);
      drive(1, 1'b1, 1'b1, 8'h41, 8'h55);
      mid();
      chk("post_rst_wr_tie", {30'd0, c1_gnt, c0_gnt}, 32'd1);
      cyc_start();
      drive(0, 1'b1, 1'b0, 8'h40, 8'h00);
      drive(1, 1'b1, 1'b0, 8'h41, 8'h00);
      mid();
      chk("post_rst_rd_tie", {30'd0, c1_gnt, c0_gnt}, 32'd1);
      cyc_start(); idle();
      repeat (4) cyc_start();
      chk("sb_drained", q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
